// File: rtl/legv8_pkg.sv
// Shared LEGv8 control encodings: branch types, condition codes, NZCV bit
// positions and the branch-resolve FSM states.
package legv8_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_CBZ   = 3'd2,
    BR_CBNZ  = 3'd3,
    BR_BCOND = 3'd4,
    BR_BR    = 3'd5
  } br_type_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  // Codes 6 and 7 are reserved and behave exactly like NONE.
  function automatic logic is_branch_type(input logic [2:0] t);
    return (t == BR_B) || (t == BR_CBZ) || (t == BR_CBNZ) ||
           (t == BR_BCOND) || (t == BR_BR);
  endfunction

endpackage

// File: rtl/legv8_cond_eval.sv
// Combinational B.cond / CSEL condition evaluator: cond + NZCV -> pass.
module legv8_cond_eval
  import legv8_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  logic base;

  assign n = flags[NZCV_N];
  assign z = flags[NZCV_Z];
  assign c = flags[NZCV_C];
  assign v = flags[NZCV_V];

  // Even codes are the base test; odd codes invert it, except NV which is always true.
  always_comb begin
    base = 1'b0;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    pass = (cond[0] && (cond != COND_NV)) ? ~base : base;
  end

endmodule

// File: rtl/legv8_branch_resolve.sv
// Registered MEM-stage branch resolution: decides taken/target, pulses pc_src,
// squashes wrong-path slots and keeps saturating branch statistics.
//
// state    | meaning
// ST_RUN   | accepting MEM-stage slots, resolving valid branches
// ST_FLUSH | squashing wrong-path slots; in_valid ignored until counter hits 0
module legv8_branch_resolve
  import legv8_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [2:0]        br_type,
  input  logic [3:0]        cond,
  input  logic [3:0]        flags,
  input  logic [DATA_W-1:0] operand,
  input  logic [ADDR_W-1:0] target,
  output logic              pc_src,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int FCNT_W = $clog2(FLUSH_DEPTH + 1);

  br_state_e         state;
  logic [FCNT_W-1:0] flush_cnt;
  logic              cond_pass;
  logic              is_branch;
  logic              taken;
  logic              op_zero;
  logic [ADDR_W-1:0] br_addr;
  logic [ADDR_W-1:0] next_target;

  legv8_cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  generate
    if (DATA_W >= ADDR_W) begin : g_br_trunc
      assign br_addr = operand[ADDR_W-1:0];
    end else begin : g_br_zext
      assign br_addr = {{(ADDR_W-DATA_W){1'b0}}, operand};
    end
  endgenerate

  assign op_zero   = (operand == '0);
  assign is_branch = in_valid && is_branch_type(br_type);

  always_comb begin
    taken       = 1'b0;
    next_target = target;
    case (br_type)
      BR_B:     taken = 1'b1;
      BR_CBZ:   taken = op_zero;
      BR_CBNZ:  taken = ~op_zero;
      BR_BCOND: taken = cond_pass;
      BR_BR: begin
        taken       = 1'b1;
        next_target = br_addr;
      end
      default:  taken = 1'b0;
    endcase
  end

  // Stall freezes everything, including a pc_src pulse that is already high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_RUN;
      flush_cnt    <= '0;
      pc_src       <= 1'b0;
      pc_target    <= '0;
      flush        <= 1'b0;
      branch_count <= '0;
      taken_count  <= '0;
    end else if (!stall) begin
      pc_src <= 1'b0;
      case (state)
        ST_RUN: begin
          if (is_branch) begin
            if (~&branch_count) branch_count <= branch_count + CNT_W'(1);
            if (taken) begin
              if (~&taken_count) taken_count <= taken_count + CNT_W'(1);
              pc_src    <= 1'b1;
              pc_target <= next_target;
              flush     <= 1'b1;
              flush_cnt <= FCNT_W'(FLUSH_DEPTH);
              state     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - FCNT_W'(1);
          if (flush_cnt == FCNT_W'(1)) begin
            flush <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule
